seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
- Multi-cycle, parametrised successor to the fixed 12-bit 4-bit-block ripple adder.
- Adds or subtracts two WIDTH-bit operands one CHUNK-bit slice per clock, LSB slice first, with a registered carry between slices.
- Adds a start/done handshake, a subtract mode, signed-overflow detection and optional signed saturation.
- Serves the DLX TinyML accumulate path, where area matters more than single-cycle latency.

Parameters:
- WIDTH, 12, operand/result width; must be a multiple of CHUNK (elaboration error otherwise).
- CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived localparam; number of RUN cycles.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only in IDLE or DONE_S.
- A  input  WIDTH  operand A, captured when START is accepted.
- B  input  WIDTH  operand B, captured when START is accepted.
- Cin  input  1  carry-in; used only when SUB=0.
- SUB  input  1  1: compute A-B (B inverted, carry-in forced to 1, Cin ignored).
- SAT  input  1  1: clamp signed overflow to the signed max/min.
- BUSY  output  1  high in RUN.
- DONE  output  1  one-cycle pulse; SUM, Cout and OVF are new in that cycle.
- SUM  output  WIDTH  registered result; holds until the next completion.
- Cout  output  1  raw unsigned carry-out of the MSB.
- OVF  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE. BUSY, DONE, SUM, Cout, OVF and all internal registers are 0.
- States: IDLE, RUN, DONE_S.
  - IDLE: if START, capture A, B^{WIDTH{SUB}}, carry = SUB ? 1 : Cin, SAT; set slice counter=0; go to RUN.
  - RUN: each edge adds slice[cnt] of A and B' plus the carry register, stores the slice sum into the internal result register, updates the carry, and increments cnt. After the edge that processes slice NCHUNK-1, go to DONE_S and load SUM/Cout/OVF.
  - DONE_S: DONE=1 for exactly one cycle. On the next edge, START=1 goes to RUN with new operands (back-to-back allowed); otherwise go to IDLE.
- Latency: START sampled at edge 0 gives BUSY=1 after edges 0..N-1 and DONE=1 in the cycle after edge N (N=NCHUNK). Throughput is one operation per N+1 cycles back-to-back.
- NCHUNK=1: a single RUN cycle; DONE follows one cycle after START.
- START while in RUN is ignored; operands are not re-captured.
- SUM, Cout and OVF change only on the edge entering DONE_S. They are stable during RUN and IDLE, showing the previous result.
- Overflow: OVF = c_msb_in XOR c_msb_out, computed in the final slice. OVF is reported whether or not SAT is set.
- Saturation (captured SAT=1 and OVF=1):
  - SUM = 0 followed by WIDTH-1 ones if A[MSB]=0.
  - SUM = 1 followed by WIDTH-1 zeros if A[MSB]=1.
  - Cout is still the raw carry.
- Arithmetic is modulo 2^WIDTH. Subtraction Cout = 1 means no borrow (A >= B unsigned).
- Reset mid-operation aborts immediately; no DONE is produced.
- Counter width is clog2(NCHUNK), minimum 1. The counter never exceeds NCHUNK-1.

Test Plan (WIDTH=12, CHUNK=4 unless noted):
- START with A=0x123, B=0x456, Cin=0, SUB=0 -> DONE exactly 3 cycles after the START edge; SUM=0x579, Cout=0, OVF=0; BUSY high for 3 cycles.
- A=0xFFF, B=0x001, Cin=0 -> SUM=0x000, Cout=1, OVF=0. Then A=0x0FF, B=0x000, Cin=1 -> SUM=0x100 (carry ripples across a slice boundary).
- SUB=1, A=0x005, B=0x007, Cin=1 (ignored) -> SUM=0xFFE, Cout=0, OVF=0. Then A=0x800, B=0x001 -> SUM=0x7FF, OVF=1, Cout=1.
- A=0x7FF, B=0x001: SAT=0 -> SUM=0x800, OVF=1; SAT=1 -> SUM=0x7FF, OVF=1. A=0x800, B=0xFFF, SAT=1 -> SUM=0x800, Cout=1, OVF=1.
- Handshake checks:
  - START re-pulsed in RUN with other operands -> ignored, original result returned.
  - START held high in the DONE_S cycle -> new op starts, DONE again 4 cycles later.
  - RST_N=0 in the 2nd RUN cycle -> BUSY, DONE and SUM are 0 immediately; no DONE follows.
- Parameter sweeps WIDTH=32/CHUNK=8 and WIDTH=8/CHUNK=8, 1000 random ops each, checked against a behavioural model -> results match; DONE latency 4 and 1 cycles respectively.

Source files
------------

// File: rtl/seq_chunk_adder_if.sv
// Handshake and operand/result bundle for seq_chunk_adder.
// The master side drives a request; the slave side (the adder) returns status and result.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 12
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             SUB;
  logic             SAT;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] SUM;
  logic             Cout;
  logic             OVF;

  modport master (
    output START, A, B, Cin, SUB, SAT,
    input  BUSY, DONE, SUM, Cout, OVF
  );

  modport slave (
    input  START, A, B, Cin, SUB, SAT,
    output BUSY, DONE, SUM, Cout, OVF
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock, LSB first, with a registered
// inter-slice carry, signed-overflow detection and optional signed saturation.
module seq_chunk_adder #(
  parameter int WIDTH = 12,
  parameter int CHUNK = 4
) (
  input logic              CLK,
  input logic              RST_N,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE_S} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
  logic             carry_q, sat_q, cout_q, ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept, last_slice;
  logic [CHUNK-1:0] slice_a, slice_b, slice_s;
  logic             slice_cout, msb_cin;
  logic [WIDTH-1:0] res_nx;

  // Clamp toward the operand A sign: an overflow always has the opposite sign to A.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                input logic ovf, input logic sat,
                                                input logic a_msb);
    logic [WIDTH-1:0] clamp;
    clamp = {a_msb, {(WIDTH-1){~a_msb}}};
    return (sat && ovf) ? clamp : raw;
  endfunction

  assign accept     = ((state == IDLE) || (state == DONE_S)) && bus.START;
  assign last_slice = (cnt_q == LAST_CNT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_slice) state_nx = DONE_S;
      DONE_S:  state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.BUSY = (state == RUN);
    bus.DONE = (state == DONE_S);
  end

  // Slice datapath; the carry into the slice MSB recovers from a ^ b ^ s at that bit.
  always_comb begin
    slice_a = a_q[int'(cnt_q) * CHUNK +: CHUNK];
    slice_b = b_q[int'(cnt_q) * CHUNK +: CHUNK];
    {slice_cout, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_q};
    msb_cin = slice_a[CHUNK-1] ^ slice_b[CHUNK-1] ^ slice_s[CHUNK-1];
    res_nx = res_q;
    res_nx[int'(cnt_q) * CHUNK +: CHUNK] = slice_s;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.A;
      b_q     <= bus.B ^ {WIDTH{bus.SUB}};
      carry_q <= bus.SUB | bus.Cin;
      sat_q   <= bus.SAT;
      res_q   <= '0;
      cnt_q   <= '0;
    end else if (state == RUN) begin
      res_q   <= res_nx;
      carry_q <= slice_cout;
      if (last_slice) begin
        sum_q  <= saturate(res_nx, msb_cin ^ slice_cout, sat_q, a_q[WIDTH-1]);
        cout_q <= slice_cout;
        ovf_q  <= msb_cin ^ slice_cout;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.SUM  = sum_q;
  assign bus.Cout = cout_q;
  assign bus.OVF  = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three instances (12/4, 32/8, 8/8) checked against a
// plain-arithmetic model through one shared expectation queue.
module tb_seq_chunk_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(12)) if0 ();
  seq_chunk_adder_if #(.WIDTH(32)) if1 ();
  seq_chunk_adder_if #(.WIDTH(8))  if2 ();

  seq_chunk_adder #(.WIDTH(12), .CHUNK(4)) dut0 (.CLK(clk), .RST_N(rst_n), .bus(if0));
  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut1 (.CLK(clk), .RST_N(rst_n), .bus(if1));
  seq_chunk_adder #(.WIDTH(8),  .CHUNK(8)) dut2 (.CLK(clk), .RST_N(rst_n), .bus(if2));

  localparam int NCH [3] = '{3, 4, 1};
  localparam int WID [3] = '{12, 32, 8};

  logic [63:0] sum_w [3];
  logic        done_w[3], busy_w[3], cout_w[3], ovf_w[3];
  assign sum_w[0] = 64'(if0.SUM);  assign done_w[0] = if0.DONE;  assign busy_w[0] = if0.BUSY;
  assign cout_w[0] = if0.Cout;     assign ovf_w[0] = if0.OVF;
  assign sum_w[1] = 64'(if1.SUM);  assign done_w[1] = if1.DONE;  assign busy_w[1] = if1.BUSY;
  assign cout_w[1] = if1.Cout;     assign ovf_w[1] = if1.OVF;
  assign sum_w[2] = 64'(if2.SUM);  assign done_w[2] = if2.DONE;  assign busy_w[2] = if2.BUSY;
  assign cout_w[2] = if2.Cout;     assign ovf_w[2] = if2.OVF;

  typedef struct {
    int          k;
    logic [63:0] s;
    logic        co;
    logic        ov;
    int          dc;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          n_pass = 0;
  int          n_tot  = 0;
  int          cyc    = 0;
  logic [63:0] last_sum[3] = '{64'd0, 64'd0, 64'd0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void fail_now(string name, int k);
    n_tot++;
    $display("FAIL %s: instance %0d at cycle %0d", name, k, cyc);
  endfunction

  // Reference: whole-word modular add of A and B (or ~B + 1), signed overflow from operand signs.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub, input logic sat,
                                output logic [63:0] s, output logic co, output logic ov);
    logic [64:0] mask, aa, bb, full;
    logic        sa, sb, sr;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & mask;
    bb   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
    full = aa + bb + (sub ? 65'd1 : {64'd0, cin});
    s    = full[63:0] & mask[63:0];
    co   = full[w];
    sa   = aa[w-1];
    sb   = bb[w-1];
    sr   = s[w-1];
    ov   = (sa == sb) && (sr != sa);
    if (sat && ov) s = sa ? (64'd1 << (w-1)) : ((64'd1 << (w-1)) - 64'd1);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (done_w[k]) begin
          if (q.size() == 0 || q[0].k != k) begin
            fail_now("unexpected_done", k);
          end else begin
            cur = q.pop_front();
            chk("sum", sum_w[k], cur.s);
            chk("cout", 64'(cout_w[k]), 64'(cur.co));
            chk("ovf", 64'(ovf_w[k]), 64'(cur.ov));
            chk("done_cycle", 64'(cyc), 64'(cur.dc));
            last_sum[k] = sum_w[k];
          end
        end else begin
          if (q.size() != 0 && q[0].k == k && cyc > q[0].dc) begin
            fail_now("missing_done", k);
            void'(q.pop_front());
          end
          chk("sum_hold", sum_w[k], last_sum[k]);
        end
      end
    end
  end

  task automatic set_in(int k, logic st, logic [63:0] a, logic [63:0] b,
                        logic cin, logic sub, logic sat);
    case (k)
      0: begin if0.START = st; if0.A = a[11:0]; if0.B = b[11:0];
               if0.Cin = cin; if0.SUB = sub; if0.SAT = sat; end
      1: begin if1.START = st; if1.A = a[31:0]; if1.B = b[31:0];
               if1.Cin = cin; if1.SUB = sub; if1.SAT = sat; end
      default: begin if2.START = st; if2.A = a[7:0]; if2.B = b[7:0];
               if2.Cin = cin; if2.SUB = sub; if2.SAT = sat; end
    endcase
  endtask

  task automatic set_start(int k, logic v);
    case (k)
      0:       if0.START = v;
      1:       if1.START = v;
      default: if2.START = v;
    endcase
  endtask

  // imm: issue in the current (DONE) cycle; rep: re-pulse START with other operands mid-run.
  task automatic op(int k, logic [63:0] a, logic [63:0] b, logic cin, logic sub,
                    logic sat, bit imm, bit rep);
    logic [63:0] s;
    logic        co, ov;
    int          busy;
    bit          got;
    model(WID[k], a, b, cin, sub, sat, s, co, ov);
    if (!imm) @(negedge clk);
    set_in(k, 1'b1, a, b, cin, sub, sat);
    q.push_back('{k: k, s: s, co: co, ov: ov, dc: cyc + 1 + NCH[k]});
    @(negedge clk);
    set_start(k, 1'b0);
    busy = 0;
    got  = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (rep && i == 1) set_in(k, 1'b1, ~a, a, ~cin, ~sub, ~sat);
      if (rep && i == 2) set_start(k, 1'b0);
      if (done_w[k]) got = 1'b1;
      else begin
        if (busy_w[k]) busy++;
        @(negedge clk);
      end
    end
    if (!got) fail_now("done_timeout", k);
    chk("busy_cycles", 64'(busy), 64'(NCH[k]));
  endtask

  task automatic dir(string nm, logic [63:0] a, logic [63:0] b, logic cin, logic sub,
                     logic sat, logic [63:0] es, logic ec, logic eo);
    logic [63:0] s;
    logic        co, ov;
    model(12, a, b, cin, sub, sat, s, co, ov);
    chk({nm, "_model_sum"}, s, es);
    chk({nm, "_model_cout"}, 64'(co), 64'(ec));
    chk({nm, "_model_ovf"}, 64'(ov), 64'(eo));
    op(0, a, b, cin, sub, sat, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) set_in(k, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    #22;
    for (int k = 0; k < 3; k++) begin
      chk("reset_busy", 64'(busy_w[k]), 64'd0);
      chk("reset_done", 64'(done_w[k]), 64'd0);
      chk("reset_sum", sum_w[k], 64'd0);
      chk("reset_cout", 64'(cout_w[k]), 64'd0);
      chk("reset_ovf", 64'(ovf_w[k]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    dir("add_basic",   64'h123, 64'h456, 1'b0, 1'b0, 1'b0, 64'h579, 1'b0, 1'b0);
    dir("add_wrap",    64'hFFF, 64'h001, 1'b0, 1'b0, 1'b0, 64'h000, 1'b1, 1'b0);
    dir("add_cin",     64'h0FF, 64'h000, 1'b1, 1'b0, 1'b0, 64'h100, 1'b0, 1'b0);
    dir("sub_neg",     64'h005, 64'h007, 1'b1, 1'b1, 1'b0, 64'hFFE, 1'b0, 1'b0);
    dir("sub_ovf",     64'h800, 64'h001, 1'b0, 1'b1, 1'b0, 64'h7FF, 1'b1, 1'b1);
    dir("add_ovf",     64'h7FF, 64'h001, 1'b0, 1'b0, 1'b0, 64'h800, 1'b0, 1'b1);
    dir("sat_pos",     64'h7FF, 64'h001, 1'b0, 1'b0, 1'b1, 64'h7FF, 1'b0, 1'b1);
    dir("sat_neg",     64'h800, 64'hFFF, 1'b0, 1'b0, 1'b1, 64'h800, 1'b1, 1'b1);

    op(0, 64'h321, 64'h111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    op(0, 64'h100, 64'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    op(0, 64'h0AA, 64'h055, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Abort in the second RUN cycle: everything clears and no completion follows.
    @(negedge clk);
    set_in(0, 1'b1, 64'h155, 64'h0AA, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_start(0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    last_sum[0] = 64'd0;
    #1;
    chk("abort_busy", 64'(busy_w[0]), 64'd0);
    chk("abort_done", 64'(done_w[0]), 64'd0);
    chk("abort_sum", sum_w[0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    op(0, 64'h001, 64'h002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        op(k, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           (i > 0) && ($urandom_range(0, 1) == 1), 1'b0);
      end
    end

    repeat (4) @(negedge clk);
    if (q.size() != 0) fail_now("pending_results", q[0].k);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
